leaf_stream_fifo: RTL and testbench

- Elastic vld/ack stream buffer on the user clock domain.
- Sits directly between a leaf_interface output port (dout_leaf_interface2user_N / vld / ack) and the HLS operator input (Input_N_V_V / ap_vld / ap_ack).
- Decouples operator stalls from the interface and gives the operator first-word-fall-through data.
- Exposes occupancy and almost-full status for freespace/credit logic.

---
 rtl/leaf_pkg.sv | 25 ++
 rtl/leaf_fifo_mem.sv | 35 +++
 rtl/leaf_stream_fifo.sv | 112 +++++++++++
 tb/tb_leaf_stream_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | leaf_pkg : shared constants, stream word type and width helper     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package leaf_pkg;

  localparam int LEAF_PAYLOAD_BITS = 32;

  typedef logic [LEAF_PAYLOAD_BITS-1:0] leaf_word_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | leaf_fifo_mem : simple dual-port RAM, one write / one sync read    |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module leaf_fifo_mem #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_BITS)-1];
  logic [WIDTH-1:0] r_rdata;

  // Read-before-write on an address collision; the caller bypasses that case.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/leaf_stream_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | leaf_stream_fifo : FWFT vld/ack elastic buffer with occupancy flags|
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module leaf_stream_fifo
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS       = LEAF_PAYLOAD_BITS,
  parameter int DEPTH_BITS         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [DEPTH_BITS:0]     count,
  output logic                    almost_full
);

  localparam int PTR_W = clog2(1 << DEPTH_BITS) + 1;
  localparam logic [PTR_W-1:0] c_af_thresh = PTR_W'(ALMOST_FULL_THRESH);
  localparam logic [PTR_W-1:0] c_one       = PTR_W'(1);

  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_count;
  logic                    r_af;
  logic                    r_sel_byp;
  logic [PAYLOAD_BITS-1:0] r_byp;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [PTR_W-1:0]        w_rd_ptr_nxt;
  logic                    w_head_load;
  logic                    w_bypass;
  logic                    w_re;
  logic [PTR_W-1:0]        w_count_nxt;
  logic [PAYLOAD_BITS-1:0] w_mem_rdata;

  assign w_full  = (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]) &&
                   (r_wr_ptr[PTR_W-1]   != r_rd_ptr[PTR_W-1]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = vld_in && !w_full;
  assign w_pop   = !w_empty && ack_in;

  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_one) : r_rd_ptr;
  assign w_head_load  = w_pop || (w_empty && w_push);
  // The new head is the word being written this cycle: take it straight from din.
  assign w_bypass     = w_push && (r_wr_ptr[PTR_W-2:0] == w_rd_ptr_nxt[PTR_W-2:0]);
  assign w_re         = w_head_load && !w_bypass;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_one;
      2'b01:   w_count_nxt = r_count - c_one;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_user) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_af      <= 1'b0;
      r_sel_byp <= 1'b1;
      r_byp     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_af     <= (w_count_nxt >= c_af_thresh);
      if (w_bypass) begin
        r_sel_byp <= 1'b1;
        r_byp     <= din;
      end else if (w_head_load) begin
        r_sel_byp <= 1'b0;
      end
    end
  end

  leaf_fifo_mem #(
    .WIDTH      (PAYLOAD_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_mem (
    .clk     (clk_user),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[PTR_W-2:0]),
    .i_wdata (din),
    .i_re    (w_re),
    .i_raddr (w_rd_ptr_nxt[PTR_W-2:0]),
    .o_rdata (w_mem_rdata)
  );

  assign ack_out     = !w_full;
  assign vld_out     = !w_empty;
  assign dout        = r_sel_byp ? r_byp : w_mem_rdata;
  assign count       = r_count;
  assign almost_full = r_af;

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_leaf_stream_fifo : directed + scoreboard bench for the FIFO     |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module tb_leaf_stream_fifo;
  import leaf_pkg::*;

  logic       clk_user;
  logic       reset;
  leaf_word_t din;
  logic       vld_in;
  logic       ack_out;
  leaf_word_t dout;
  logic       vld_out;
  logic       ack_in;
  logic [4:0] count;
  logic       almost_full;

  int n_checks = 0;
  int n_errors = 0;
  leaf_word_t model_q[$];

  leaf_stream_fifo #(
    .PAYLOAD_BITS       (32),
    .DEPTH_BITS         (4),
    .ALMOST_FULL_THRESH (12)
  ) dut (
    .clk_user    (clk_user),
    .reset       (reset),
    .din         (din),
    .vld_in      (vld_in),
    .ack_out     (ack_out),
    .dout        (dout),
    .vld_out     (vld_out),
    .ack_in      (ack_in),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk_user = 1'b0;
  always #5 clk_user = ~clk_user;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  // Check state against the model, apply this cycle's transfers, advance one clock.
  task automatic tick(output bit pushed);
    bit exp_ack;
    bit exp_vld;
    exp_ack = (model_q.size() < 16);
    exp_vld = (model_q.size() > 0);
    pushed  = 1'b0;
    chk("count", 64'(count), 64'(model_q.size()));
    chk("almost_full", 64'(almost_full), 64'(model_q.size() >= 12));
    chk("ack_out", 64'(ack_out), 64'(exp_ack));
    chk("vld_out", 64'(vld_out), 64'(exp_vld));
    if (exp_vld && ack_in) begin
      chk("dout", 64'(dout), 64'(model_q[0]));
      void'(model_q.pop_front());
    end
    if (exp_ack && vld_in) begin
      model_q.push_back(din);
      pushed = 1'b1;
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    int pushed_n;
    int cycles;

    reset = 1'b1; din = '0; vld_in = 1'b0; ack_in = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ack_out", 64'(ack_out), 64'd1);
    chk("rst_vld_out", 64'(vld_out), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_almost_full", 64'(almost_full), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);

    // Single word, FWFT latency of one cycle.
    din = 32'hDEADBEEF; vld_in = 1'b1; ack_in = 1'b1;
    tick(p);
    vld_in = 1'b0;
    chk("single_vld", 64'(vld_out), 64'd1);
    chk("single_dout", 64'(dout), 64'hDEADBEEF);
    tick(p);
    chk("single_vld_after", 64'(vld_out), 64'd0);
    chk("single_count_after", 64'(count), 64'd0);

    // Fill to full with the operator stalled.
    ack_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 32'(i); vld_in = 1'b1;
      tick(p);
      chk("fill_af", 64'(almost_full), 64'((i + 1) >= 12));
    end
    chk("full_ack_out", 64'(ack_out), 64'd0);
    chk("full_count", 64'(count), 64'd16);
    din = 32'd16;
    for (int i = 0; i < 3; i++) tick(p);
    chk("full_hold_count", 64'(count), 64'd16);
    ack_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(p);
      if (p) vld_in = 1'b0;
    end
    chk("drain_empty", 64'(vld_out), 64'd0);
    chk("drain_model_empty", 64'(model_q.size()), 64'd0);

    // Continuous streaming at one word per cycle.
    pushed_n = 0; cycles = 0;
    din = 32'd1; vld_in = 1'b1; ack_in = 1'b1;
    while (pushed_n < 100 && cycles < 300) begin
      tick(p);
      cycles++;
      if (p) begin
        pushed_n++;
        din = din + 32'd1;
      end
    end
    vld_in = 1'b0;
    chk("stream_cycles", 64'(cycles), 64'd100);
    chk("stream_count", 64'(count), 64'd1);
    tick(p);
    chk("stream_drained", 64'(vld_out), 64'd0);

    // Random backpressure on both sides.
    pushed_n = 0; cycles = 0;
    din = $urandom; vld_in = 1'($urandom_range(0, 1)); ack_in = 1'($urandom_range(0, 1));
    while (pushed_n < 1000 && cycles < 20000) begin
      tick(p);
      cycles++;
      if (p) begin
        pushed_n++;
        din = $urandom;
      end
      vld_in = (pushed_n < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      ack_in = 1'($urandom_range(0, 1));
    end
    chk("rand_pushed", 64'(pushed_n), 64'd1000);
    vld_in = 1'b0; ack_in = 1'b1;
    cycles = 0;
    while (model_q.size() > 0 && cycles < 40) begin
      tick(p);
      cycles++;
    end
    chk("rand_drained", 64'(vld_out), 64'd0);
    chk("rand_model_empty", 64'(model_q.size()), 64'd0);

    // Reset with seven words queued and both handshakes active.
    ack_in = 1'b0; vld_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = 32'h100 + 32'(i);
      tick(p);
    end
    chk("pre_reset_count", 64'(count), 64'd7);
    reset = 1'b1; ack_in = 1'b1; din = 32'h12345678;
    step();
    reset = 1'b0; vld_in = 1'b0; ack_in = 1'b0;
    model_q.delete();
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_vld_out", 64'(vld_out), 64'd0);
    chk("midrst_ack_out", 64'(ack_out), 64'd1);
    din = 32'hA5A5A5A5; vld_in = 1'b1;
    tick(p);
    vld_in = 1'b0;
    chk("post_rst_vld", 64'(vld_out), 64'd1);
    chk("post_rst_dout", 64'(dout), 64'hA5A5A5A5);
    ack_in = 1'b1;
    tick(p);
    chk("post_rst_empty", 64'(vld_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
